// File: rtl/tc_preset_bank_pkg.sv
// -----------------------------------------------------------------------------
// tc_preset_bank_pkg
// Shared definitions for the timer/counter preset bank:
//   - sweep FSM state encoding (ST_IDLE = 1'b0, ST_SWEEP = 1'b1)
//   - default PRESET_W / NUM_TC / ADDR_W values
// Optional feature switch: TC_PRESET_READBACK_EN (define at build time to add
// the rd_addr/rd_data shadow readback port on tc_preset_bank).
// -----------------------------------------------------------------------------
package tc_preset_bank_pkg;

  localparam int DEF_PRESET_W = 8;
  localparam int DEF_NUM_TC   = 16;
  localparam int DEF_ADDR_W   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/tc_preset_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tc_preset_sweep_ctrl
// Commit sweep sequencer: walks channel 0..NUM_TC-1, one per cycle, after a
// commit request seen in idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_commit; shadow writes are accepted
// ST_SWEEP | processing channel r_ch this cycle; writes are refused
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   i_commit      in   sweep request (level, sampled in ST_IDLE only)
//   o_busy        out  sweep in progress (high exactly NUM_TC cycles)
//   o_sweep_ch    out  channel handled this cycle
//   o_sweep_step  out  a channel is handled this cycle
// -----------------------------------------------------------------------------
module tc_preset_sweep_ctrl
  import tc_preset_bank_pkg::*;
#(
  parameter int NUM_TC = DEF_NUM_TC,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_commit,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sweep_ch,
  output logic              o_sweep_step
);

  // Counter stops at the last real channel, so non-power-of-2 banks never wrap.
  localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(NUM_TC - 1);

  sweep_state_t      r_state;
  logic [ADDR_W-1:0] r_ch;
  logic              r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_commit) begin
            r_state <= ST_SWEEP;
            r_ch    <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (r_ch == LAST_CH) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_sweep_ch   = r_ch;
  assign o_sweep_step = r_busy;

endmodule

// File: rtl/tc_preset_bank.sv
// -----------------------------------------------------------------------------
// tc_preset_bank
// Preset register bank for the timer/counter array. Presets are written into
// shadow registers and moved into the active bank by a commit sweep; each
// channel that changes raises a one-cycle reload strobe.
//
// Ports:
//   clk, reset    clock (rising edge), asynchronous active-high reset
//   wr_en/addr/data  shadow write request; accepted when wr_en && wr_ready
//   wr_ready      out  ~busy; writes while busy are dropped
//   commit        in   start a commit sweep (level sampled in idle)
//   busy          out  sweep in progress
//   dirty         out  per-channel pending shadow value
//   preset_out    out  active presets, channel i at [i*PRESET_W +: PRESET_W]
//   reload        out  per-channel one-cycle strobe on active update
//   rd_addr/rd_data  registered shadow readback (TC_PRESET_READBACK_EN only)
//
// Build switch: TC_PRESET_READBACK_EN adds the readback port and its mux.
// -----------------------------------------------------------------------------
module tc_preset_bank
  import tc_preset_bank_pkg::*;
#(
  parameter int PRESET_W = DEF_PRESET_W,
  parameter int NUM_TC   = DEF_NUM_TC,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef TC_PRESET_READBACK_EN
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [PRESET_W-1:0]        rd_data,
`endif
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [PRESET_W-1:0]        wr_data,
  output logic                       wr_ready,
  input  logic                       commit,
  output logic                       busy,
  output logic [NUM_TC-1:0]          dirty,
  output logic [PRESET_W*NUM_TC-1:0] preset_out,
  output logic [NUM_TC-1:0]          reload
);

  // One extra bit so NUM_TC == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NUM_TC_X = (ADDR_W + 1)'(NUM_TC);

  logic [PRESET_W-1:0] r_shadow [NUM_TC];
  logic [PRESET_W-1:0] r_active [NUM_TC];
  logic [NUM_TC-1:0]   r_dirty;
  logic [NUM_TC-1:0]   r_reload;

  logic                w_busy;
  logic                w_sweep_step;
  logic [ADDR_W-1:0]   w_sweep_ch;
  logic                w_wr_accept;

  tc_preset_sweep_ctrl #(
    .NUM_TC (NUM_TC),
    .ADDR_W (ADDR_W)
  ) u_sweep_ctrl (
    .clk          (clk),
    .reset        (reset),
    .i_commit     (commit),
    .o_busy       (w_busy),
    .o_sweep_ch   (w_sweep_ch),
    .o_sweep_step (w_sweep_step)
  );

  // Writes only land in idle, sweep updates only happen while busy, so the
  // two never touch the same dirty bit in one cycle.
  assign w_wr_accept = wr_en & ~w_busy & ({1'b0, wr_addr} < NUM_TC_X);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TC; i++) r_shadow[i] <= '0;
    end else if (w_wr_accept) begin
      r_shadow[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TC; i++) r_active[i] <= '0;
      r_dirty  <= '0;
      r_reload <= '0;
    end else begin
      r_reload <= '0;
      if (w_wr_accept) r_dirty[wr_addr] <= 1'b1;
      if (w_sweep_step && r_dirty[w_sweep_ch]) begin
        r_active[w_sweep_ch] <= r_shadow[w_sweep_ch];
        r_dirty[w_sweep_ch]  <= 1'b0;
        r_reload[w_sweep_ch] <= 1'b1;
      end
    end
  end

`ifdef TC_PRESET_READBACK_EN
  logic [PRESET_W-1:0] r_rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if ({1'b0, rd_addr} < NUM_TC_X) begin
      r_rd_data <= r_shadow[rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data = r_rd_data;
`endif

  for (genvar g = 0; g < NUM_TC; g++) begin : g_preset
    assign preset_out[g*PRESET_W +: PRESET_W] = r_active[g];
  end

  assign wr_ready = ~w_busy;
  assign busy     = w_busy;
  assign dirty    = r_dirty;
  assign reload   = r_reload;

endmodule

// File: tb/tb_tc_preset_bank.sv
module tb_tc_preset_bank;

  localparam int PW = 8;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          wr_ready;
  logic          commit;
  logic          busy;
  logic [N-1:0]  dirty;
  logic [PW*N-1:0] preset_out;
  logic [N-1:0]  reload;
`ifdef TC_PRESET_READBACK_EN
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic [PW-1:0] m_rd;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: shadow/active arrays, pending flags, and the index of the
  // channel a sweep will handle on the next edge (-1 when no sweep is running).
  logic [PW-1:0] m_shadow [N];
  logic [PW-1:0] m_active [N];
  logic [N-1:0]  m_dirty;
  logic [N-1:0]  m_reload;
  int            m_idx;

  always #5 clk = ~clk;

  tc_preset_bank #(.PRESET_W(PW), .NUM_TC(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef TC_PRESET_READBACK_EN
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
`endif
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .commit     (commit),
    .busy       (busy),
    .dirty      (dirty),
    .preset_out (preset_out),
    .reload     (reload)
  );

  task automatic check(input string tag, input logic [PW*N-1:0] obs, input logic [PW*N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_dirty  = '0;
    m_reload = '0;
    m_idx    = -1;
`ifdef TC_PRESET_READBACK_EN
    m_rd = '0;
`endif
  endtask

  // Apply the effect of one rising edge given the inputs currently driven.
  task automatic model_edge();
    logic [N-1:0] nr;
    nr = '0;
    if (reset) begin
      model_reset();
      return;
    end
`ifdef TC_PRESET_READBACK_EN
    m_rd = (int'(rd_addr) < N) ? m_shadow[rd_addr] : '0;
`endif
    if (m_idx >= 0) begin
      if (m_dirty[m_idx]) begin
        m_active[m_idx] = m_shadow[m_idx];
        m_dirty[m_idx]  = 1'b0;
        nr[m_idx]       = 1'b1;
      end
      m_idx = (m_idx == N - 1) ? -1 : m_idx + 1;
    end else begin
      if (wr_en && int'(wr_addr) < N) begin
        m_shadow[wr_addr] = wr_data;
        m_dirty[wr_addr]  = 1'b1;
      end
      if (commit) m_idx = 0;
    end
    m_reload = nr;
  endtask

  function automatic logic [PW*N-1:0] m_preset();
    logic [PW*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = m_active[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".preset"},   preset_out, m_preset());
    check({tag, ".dirty"},    dirty,      m_dirty);
    check({tag, ".reload"},   reload,     m_reload);
    check({tag, ".busy"},     busy,       (m_idx >= 0));
    check({tag, ".wr_ready"}, wr_ready,   (m_idx < 0));
`ifdef TC_PRESET_READBACK_EN
    check({tag, ".rd_data"},  rd_data,    m_rd);
`endif
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit  = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int rl_cnt;

    reset = 1'b1;
    idle_inputs();
`ifdef TC_PRESET_READBACK_EN
    rd_addr = '0;
`endif
    model_reset();
    #1;
    check_all("t1_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("t1_idle");

    // Single write then commit: 16 busy cycles, one reload on channel 3.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    step("t2_wr");
    idle_inputs();
    commit = 1'b1;
    step("t2_commit");
    commit = 1'b0;
    busy_cnt = busy ? 1 : 0;
    rl_cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      step("t2_sweep");
      if (busy) busy_cnt++;
      if (reload[3]) rl_cnt++;
    end
    check("t2_busy_len", busy_cnt, 16);
    check("t2_reload3_cnt", rl_cnt, 1);
    check("t2_active3", preset_out[3*PW +: PW], 8'hA5);

    // Rewrite before commit: last value wins, single strobe.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h11;
    step("t3_wr1");
    wr_data = 8'h22;
    step("t3_wr2");
    idle_inputs();
    commit = 1'b1;
    step("t3_commit");
    commit = 1'b0;
    rl_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step("t3_sweep");
      if (reload[5]) rl_cnt++;
    end
    check("t3_reload5_cnt", rl_cnt, 1);
    check("t3_active5", preset_out[5*PW +: PW], 8'h22);

    // Write during a sweep is dropped.
    commit = 1'b1;
    step("t4_commit");
    commit = 1'b0;
    step("t4_sweep1");
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h77;
    step("t4_drop");
    idle_inputs();
    check("t4_dirty0", dirty[0], 1'b0);
    for (int i = 0; i < 20; i++) step("t4_sweep");
    check("t4_active0", preset_out[0 +: PW], 8'h00);

    // Write and commit together: the write joins that sweep.
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'hC3; commit = 1'b1;
    step("t5_wr_commit");
    idle_inputs();
    for (int i = 0; i < 20; i++) step("t5_sweep");
    check("t5_active15", preset_out[15*PW +: PW], 8'hC3);

    // Reset in the middle of a sweep clears everything immediately.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h5A;
    step("t5_wr2");
    wr_addr = 4'd12; wr_data = 8'h9E; commit = 1'b1;
    step("t5_commit2");
    idle_inputs();
    for (int i = 0; i < 7; i++) step("t5_partial");
    reset = 1'b1;
    model_reset();
    #1;
    check_all("t5_async_reset");
    check("t5_preset_zero", preset_out, '0);
    check("t5_busy_zero", busy, 1'b0);
    step("t5_reset_hold");
    reset = 1'b0;
    step("t5_after_reset");

`ifdef TC_PRESET_READBACK_EN
    // Readback returns the shadow value one cycle after the address.
    rd_addr = 4'd7;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
    step("t6_rd_before");
    check("t6_rd_old", rd_data, 8'h00);
    idle_inputs();
    step("t6_rd_after");
    check("t6_rd_new", rd_data, 8'h3C);
`endif

    // Randomised traffic against the model, including occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 249) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = AW'($urandom_range(0, N - 1));
      wr_data = PW'($urandom);
      commit  = ($urandom_range(0, 11) == 0);
`ifdef TC_PRESET_READBACK_EN
      rd_addr = AW'($urandom_range(0, N - 1));
`endif
      if (reset) begin
        model_reset();
        #1;
        check_all("rnd_async_reset");
      end
      step("rnd");
    end
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 20; i++) step("rnd_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
